matrix_result_streamer: RTL and testbench
=========================================

Name: matrix_result_streamer

Overview:
- Downstream stage of the blocked matrix multiplier `matrix_mul`.
- On a rising edge of the multiplier's `done`, snapshots the flat `finals` result vector (FIRST_MATRIX_ROW_SIZE x SECOND_MATRIX_COL_SIZE elements, OUTPUT_DATA_WIDTH each).
- Streams the elements out one per accepted beat, row-major, over a valid/ready interface with row/col tags and end markers.
- Frees the multiplier for the next job as soon as the snapshot is taken.

Parameters:
- DATA_WIDTH, 16, multiplier operand width; used only to derive OUTPUT_DATA_WIDTH.
- OUTPUT_DATA_WIDTH, 2*DATA_WIDTH, width of one result element.
- FIRST_MATRIX_ROW_SIZE, 18, result rows (R).
- SECOND_MATRIX_COL_SIZE, 21, result columns (C).
- ROW_W, $clog2(FIRST_MATRIX_ROW_SIZE), width of the row tag (minimum 1).
- COL_W, $clog2(SECOND_MATRIX_COL_SIZE), width of the column tag (minimum 1).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- done_i  in  1  multiplier done level; a rising edge means `finals_i` is valid.
- finals_i  in  R*C*OUTPUT_DATA_WIDTH  flat results; element (r,c) is at `[(r*C+c)*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]`.
- out_data  out  OUTPUT_DATA_WIDTH  current element.
- out_valid  out  1  `out_data` and the tags are valid.
- out_ready  in  1  sink accepts the beat.
- out_row  out  ROW_W  row index of the current element.
- out_col  out  COL_W  column index of the current element.
- out_last_col  out  1  current element has col == C-1.
- out_last  out  1  current element is (R-1, C-1).
- busy_o  out  1  snapshot held and stream in progress.
- frame_done_o  out  1  one-cycle pulse after the final beat is accepted.
- overrun_o  out  1  sticky: a `done_i` rise arrived while busy.

Behaviour:
- Reset (reset==0, asynchronous):
  - State IDLE.
  - out_valid, busy_o, frame_done_o, overrun_o, out_last, out_last_col = 0.
  - out_row, out_col, out_data = 0.
  - done_d = 0.
  - Snapshot buffer contents don't-care.
- Edge detect: `done_d <= done_i` every cycle; `rise = done_i & ~done_d`. Because done_d resets to 0, `done_i` already high when reset is released counts as a rise.
- States: IDLE, STREAM, FINISH.
- IDLE:
  - On rise, register all of `finals_i` into the snapshot buffer, clear the row/col counters, and go to STREAM.
  - busy_o and out_valid go high on the next cycle (latency 1 from the rising edge of `done_i`).
- STREAM:
  - out_valid = 1.
  - out_data = snapshot element at row*C+col; out_row/out_col reflect the counters.
  - out_last_col = (col==C-1); out_last = (row==R-1 && col==C-1).
  - Transfer occurs when out_valid & out_ready. On transfer: col+1; at col==C-1, col wraps to 0 and row+1.
  - On transfer of the out_last beat: go to FINISH; out_valid drops the next cycle.
  - With out_ready low, all outputs hold stable (no bubbles or changes while stalled).
- FINISH:
  - frame_done_o = 1 for exactly one cycle; busy_o = 0 in that cycle.
  - Return to IDLE.
  - A rise seen during FINISH is captured exactly as in IDLE (returns to STREAM next cycle); it is not an overrun.
- Overrun: a rise during STREAM sets overrun_o (sticky until reset). The new data is dropped and the current stream continues unaffected.
- Throughput: with out_ready held high, one element per cycle. A full frame takes R*C cycles from the first valid beat to the last transfer; default is 378 beats.
- Output path: out_data is a mux off registered snapshot storage; no arithmetic and no width change.
- Reset mid-stream: the stream aborts immediately; no frame_done_o pulse; after release the block waits for a fresh rise. If `done_i` is still high at release, a rise fires and a full new snapshot is taken.
- Degenerate sizes: R==1 or C==1 must work; tag widths clamp to 1 bit.

Test Plan:
- Basic frame:
  - Stimulus: load `finals_i` with element k = 0x100+k, raise `done_i`, out_ready=1.
  - Response: 378 beats with data 0x100..0x279 in order; row/col tags (0,0)...(17,20); out_last_col on every 21st beat; out_last only on beat 377; frame_done_o 1 cycle later; out_valid first high 1 cycle after the done_i rise.
- Backpressure:
  - Stimulus: toggle out_ready pseudo-randomly (roughly 50%).
  - Response: the same 378-value sequence; out_data and tags unchanged across every stalled cycle; no beat lost or duplicated.
- Snapshot isolation:
  - Stimulus: after the rise, overwrite `finals_i` with all 0xFFFFFFFF mid-stream.
  - Response: the streamed values are still 0x100+k.
- Overrun:
  - Stimulus: drop and re-raise `done_i` at beat 50.
  - Response: overrun_o=1 (sticky); the stream completes with the original data; no second frame starts.
- Reset mid-stream:
  - Stimulus: assert reset at beat 100, release it with `done_i` low, then raise `done_i`.
  - Response: all outputs 0 immediately on reset; no frame_done_o pulse; a fresh full 378-beat frame starting at (0,0).
- Back-to-back with a real multiplier:
  - Stimulus: connect to `matrix_mul` using A[m][k]=m*60+k and B[k][n]=k*21+n.
  - Response: first beat 1474410 (C[0][0]); all 378 beats match the reference product.

Source files
------------

// File: rtl/matrix_result_streamer.sv
// Snapshots matrix_mul results on a done_i rise and streams them row-major over valid/ready with row/col tags.
// out_valid follows the done_i rise by one cycle; a stalled sink freezes every output, else one beat per cycle.
module matrix_result_streamer #(
    parameter int DATA_WIDTH             = 16,
    parameter int OUTPUT_DATA_WIDTH      = 2*DATA_WIDTH,
    parameter int FIRST_MATRIX_ROW_SIZE  = 18,
    parameter int SECOND_MATRIX_COL_SIZE = 21,
    parameter int ROW_W = (FIRST_MATRIX_ROW_SIZE  > 1) ? $clog2(FIRST_MATRIX_ROW_SIZE)  : 1,
    parameter int COL_W = (SECOND_MATRIX_COL_SIZE > 1) ? $clog2(SECOND_MATRIX_COL_SIZE) : 1
) (
    input  logic                                                                    clock,
    input  logic                                                                    reset,
    input  logic                                                                    done_i,
    input  logic [FIRST_MATRIX_ROW_SIZE*SECOND_MATRIX_COL_SIZE*OUTPUT_DATA_WIDTH-1:0] finals_i,
    output logic [OUTPUT_DATA_WIDTH-1:0]                                            out_data,
    output logic                                                                    out_valid,
    input  logic                                                                    out_ready,
    output logic [ROW_W-1:0]                                                        out_row,
    output logic [COL_W-1:0]                                                        out_col,
    output logic                                                                    out_last_col,
    output logic                                                                    out_last,
    output logic                                                                    busy_o,
    output logic                                                                    frame_done_o,
    output logic                                                                    overrun_o
);

    localparam int R     = FIRST_MATRIX_ROW_SIZE;
    localparam int C     = SECOND_MATRIX_COL_SIZE;
    localparam int N     = R * C;
    localparam int W     = OUTPUT_DATA_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(R - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(C - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic             r_done_d;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_valid;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_overrun;
    logic             r_last;
    logic             r_last_col;
    logic [W-1:0]     r_snap [N];

    logic             w_rise;
    logic             w_xfer;
    logic             w_capture;
    logic [ROW_W-1:0] w_nxt_row;
    logic [COL_W-1:0] w_nxt_col;
    int               w_idx_int;
    logic [IDX_W-1:0] w_idx;

    assign w_rise    = done_i & ~r_done_d;
    assign w_xfer    = r_valid & out_ready;
    assign w_capture = w_rise & (r_state != S_STREAM);

    assign w_nxt_col = r_last_col ? '0 : r_col + 1'b1;
    assign w_nxt_row = r_last_col ? r_row + 1'b1 : r_row;

    assign w_idx_int = int'(r_row) * C + int'(r_col);
    assign w_idx     = IDX_W'(w_idx_int);

    // Storage carries no reset; contents only matter once a capture has happened.
    always_ff @(posedge clock) begin
        if (w_capture) begin
            for (int k = 0; k < N; k++) begin
                r_snap[k] <= finals_i[k*W +: W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_done_d     <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_last       <= 1'b0;
            r_last_col   <= 1'b0;
        end else begin
            r_done_d     <= done_i;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (w_rise) begin
                        r_state    <= S_STREAM;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_last_col <= (LAST_COL == '0);
                        r_last     <= (LAST_ROW == '0) && (LAST_COL == '0);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_STREAM: begin
                    // A new result while streaming is dropped; only the sticky flag records it.
                    if (w_rise) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (r_last) begin
                            r_state      <= S_FINISH;
                            r_valid      <= 1'b0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_row        <= '0;
                            r_col        <= '0;
                            r_last       <= 1'b0;
                            r_last_col   <= 1'b0;
                        end else begin
                            r_row      <= w_nxt_row;
                            r_col      <= w_nxt_col;
                            r_last_col <= (w_nxt_col == LAST_COL);
                            r_last     <= (w_nxt_row == LAST_ROW) && (w_nxt_col == LAST_COL);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_data     = r_valid ? r_snap[w_idx] : '0;
    assign out_valid    = r_valid;
    assign out_row      = r_row;
    assign out_col      = r_col;
    assign out_last_col = r_last_col;
    assign out_last     = r_last;
    assign busy_o       = r_busy;
    assign frame_done_o = r_frame_done;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: randomized sink readiness against a row-major frame model.
module tb_matrix_result_streamer;

    localparam int R  = 18;
    localparam int C  = 21;
    localparam int N  = R * C;
    localparam int W  = 32;
    localparam int RW = 5;
    localparam int CW = 5;
    localparam int KD = 60;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [RW-1:0] r;
        logic [CW-1:0] c;
        logic          lc;
        logic          l;
    } beat_t;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           done_i = 1'b0;
    logic           out_ready = 1'b0;
    logic [N*W-1:0] finals_i = '0;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic [RW-1:0]  out_row;
    logic [CW-1:0]  out_col;
    logic           out_last_col;
    logic           out_last;
    logic           busy_o;
    logic           frame_done_o;
    logic           overrun_o;

    matrix_result_streamer dut (
        .clock        (clock),
        .reset        (reset),
        .done_i       (done_i),
        .finals_i     (finals_i),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last_col (out_last_col),
        .out_last     (out_last),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .overrun_o    (overrun_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] ref_vals [N];
    logic [W-1:0] alt_vals [N];
    beat_t        q [$];
    int           first_valid, fd_cnt, fd_cyc, stall_err, timed_out, cyc;
    logic         fd_busy;

    // Expected k-th beat of a frame: row-major walk over the captured matrix.
    function automatic beat_t exp_beat(input int k);
        beat_t b;
        b.d  = ref_vals[k];
        b.r  = RW'(k / C);
        b.c  = CW'(k % C);
        b.lc = ((k % C) == (C - 1));
        b.l  = (k == N - 1);
        return b;
    endfunction

    task automatic drive_finals(input bit use_alt);
        for (int k = 0; k < N; k++) begin
            finals_i[k*W +: W] = use_alt ? alt_vals[k] : ref_vals[k];
        end
    endtask

    task automatic start_frame();
        @(posedge clock); #1;
        done_i = 1'b0;
        @(posedge clock); #1;
        drive_finals(1'b0);
        done_i = 1'b1;
    endtask

    // act_kind: 1 overwrite finals with ones, 2 pulse done_i low then re-raise with alt data, 3 assert reset
    task automatic collect(input int ready_pct, input int act_beat, input int act_kind);
        bit    finished   = 1'b0;
        bit    pend_raise = 1'b0;
        bit    prev_stall = 1'b0;
        beat_t cur;
        beat_t prev;
        int    beats = 0;
        q.delete();
        first_valid = -1; fd_cnt = 0; fd_cyc = -1; fd_busy = 1'b0;
        stall_err = 0; timed_out = 0; cyc = 0;
        prev = '0;
        while (!finished) begin
            if (cyc >= 3000) begin
                timed_out = 1;
                break;
            end
            @(posedge clock); #1;
            if (pend_raise) begin
                drive_finals(1'b1);
                done_i = 1'b1;
                pend_raise = 1'b0;
            end
            out_ready = ($urandom_range(99) < ready_pct);
            @(negedge clock);
            cyc++;
            cur = {out_data, out_row, out_col, out_last_col, out_last};
            if (prev_stall && (!out_valid || cur !== prev)) stall_err++;
            prev_stall = out_valid && !out_ready;
            prev = cur;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (frame_done_o) begin
                fd_cnt++;
                if (fd_cyc < 0) begin
                    fd_cyc  = cyc;
                    fd_busy = busy_o;
                end
                finished = 1'b1;
            end
            if (out_valid && out_ready) begin
                q.push_back(cur);
                beats++;
                if (beats == act_beat) begin
                    case (act_kind)
                        1: finals_i = '1;
                        2: begin done_i = 1'b0; pend_raise = 1'b1; end
                        3: begin reset = 1'b0; done_i = 1'b0; finished = 1'b1; end
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; done_i = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if ({busy_o, frame_done_o, overrun_o} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {busy_o, frame_done_o, overrun_o}); end
        checks++; if ({out_last, out_last_col} !== 2'b00) begin errors++; $display("FAIL rst_last got %b want 00", {out_last, out_last_col}); end
        checks++; if ({out_row, out_col, out_data} !== '0) begin errors++; $display("FAIL rst_tags got %h/%h/%h want 0", out_row, out_col, out_data); end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if ({out_valid, busy_o} !== 2'b00) begin errors++; $display("FAIL idle_after_rst got %b want 00", {out_valid, busy_o}); end
    endtask

    task automatic test_basic();
        for (int k = 0; k < N; k++) ref_vals[k] = W'(32'h100 + k);
        start_frame();
        collect(100, -1, 0);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
        checks++; if (first_valid !== 1) begin errors++; $display("FAIL basic_latency got %0d want 1", first_valid); end
        checks++; if (q.size() !== N) begin errors++; $display("FAIL basic_count got %0d want %0d", q.size(), N); end
        for (int k = 0; k < q.size() && k < N; k++) begin
            checks++;
            if (q[k] !== exp_beat(k)) begin errors++; $display("FAIL basic_beat%0d got %h want %h", k, q[k], exp_beat(k)); end
        end
        checks++; if (fd_cyc !== N + 1) begin errors++; $display("FAIL basic_done_cycle got %0d want %0d", fd_cyc, N + 1); end
        checks++; if (fd_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", fd_busy); end
        @(negedge clock);
        checks++; if ({frame_done_o, out_valid, busy_o} !== 3'b000) begin errors++; $display("FAIL basic_after got %b want 000", {frame_done_o, out_valid, busy_o}); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < N; k++) ref_vals[k] = W'(32'h100 + k);
        start_frame();
        collect(50, -1, 0);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL bp_timeout got %0d want 0", timed_out); end
        checks++; if (q.size() !== N) begin errors++; $display("FAIL bp_count got %0d want %0d", q.size(), N); end
        for (int k = 0; k < q.size() && k < N; k++) begin
            checks++;
            if (q[k] !== exp_beat(k)) begin errors++; $display("FAIL bp_beat%0d got %h want %h", k, q[k], exp_beat(k)); end
        end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_err); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL bp_frame_done got %0d want 1", fd_cnt); end
    endtask

    task automatic test_snapshot();
        for (int k = 0; k < N; k++) ref_vals[k] = W'(32'h100 + k);
        start_frame();
        collect(70, 10, 1);
        checks++; if (q.size() !== N) begin errors++; $display("FAIL snap_count got %0d want %0d", q.size(), N); end
        for (int k = 0; k < q.size() && k < N; k++) begin
            checks++;
            if (q[k] !== exp_beat(k)) begin errors++; $display("FAIL snap_beat%0d got %h want %h", k, q[k], exp_beat(k)); end
        end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL snap_stall_stable got %0d want 0", stall_err); end
    endtask

    task automatic test_overrun();
        int seen = 0;
        for (int k = 0; k < N; k++) begin
            ref_vals[k] = W'(32'h100 + k);
            alt_vals[k] = W'(32'hDEAD0000 + k);
        end
        start_frame();
        collect(100, 50, 2);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun_o); end
        checks++; if (q.size() !== N) begin errors++; $display("FAIL ovr_count got %0d want %0d", q.size(), N); end
        for (int k = 0; k < q.size() && k < N; k++) begin
            checks++;
            if (q[k] !== exp_beat(k)) begin errors++; $display("FAIL ovr_beat%0d got %h want %h", k, q[k], exp_beat(k)); end
        end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL ovr_frame_done got %0d want 1", fd_cnt); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid || busy_o) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL ovr_no_second_frame got %0d active cycles want 0", seen); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun_o); end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        for (int k = 0; k < N; k++) ref_vals[k] = W'(32'h100 + k);
        start_frame();
        collect(100, 100, 3);
        #1;
        checks++; if ({out_valid, busy_o, frame_done_o, overrun_o, out_last, out_last_col} !== 6'b0) begin
            errors++; $display("FAIL mrst_flags got %b want 000000", {out_valid, busy_o, frame_done_o, overrun_o, out_last, out_last_col}); end
        checks++; if ({out_row, out_col, out_data} !== '0) begin errors++; $display("FAIL mrst_tags got %h/%h/%h want 0", out_row, out_col, out_data); end
        checks++; if (q.size() !== 100) begin errors++; $display("FAIL mrst_partial got %0d want 100", q.size()); end
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (out_valid || frame_done_o) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mrst_quiet got %0d active cycles want 0", seen); end
        for (int k = 0; k < N; k++) ref_vals[k] = W'($urandom);
        start_frame();
        collect(60, -1, 0);
        checks++; if (q.size() !== N) begin errors++; $display("FAIL mrst_count got %0d want %0d", q.size(), N); end
        for (int k = 0; k < q.size() && k < N; k++) begin
            checks++;
            if (q[k] !== exp_beat(k)) begin errors++; $display("FAIL mrst_beat%0d got %h want %h", k, q[k], exp_beat(k)); end
        end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL mrst_frame_done got %0d want 1", fd_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < R; m++) begin
            for (int n = 0; n < C; n++) begin
                int acc = 0;
                for (int k = 0; k < KD; k++) acc += (m * 60 + k) * (k * 21 + n);
                ref_vals[m*C + n] = W'(acc);
            end
        end
        for (int k = 0; k < N; k++) alt_vals[k] = W'($urandom);
        start_frame();
        collect(100, N, 2);
        checks++; if (q.size() !== N) begin errors++; $display("FAIL b2b_count1 got %0d want %0d", q.size(), N); end
        if (q.size() > 0) begin
            checks++; if (q[0].d !== 32'd1474410) begin errors++; $display("FAIL b2b_first got %0d want 1474410", q[0].d); end
        end
        for (int k = 0; k < q.size() && k < N; k++) begin
            checks++;
            if (q[k] !== exp_beat(k)) begin errors++; $display("FAIL b2b1_beat%0d got %h want %h", k, q[k], exp_beat(k)); end
        end
        for (int k = 0; k < N; k++) ref_vals[k] = alt_vals[k];
        collect(100, -1, 0);
        checks++; if (first_valid !== 1) begin errors++; $display("FAIL b2b_restart got %0d want 1", first_valid); end
        checks++; if (q.size() !== N) begin errors++; $display("FAIL b2b_count2 got %0d want %0d", q.size(), N); end
        for (int k = 0; k < q.size() && k < N; k++) begin
            checks++;
            if (q[k] !== exp_beat(k)) begin errors++; $display("FAIL b2b2_beat%0d got %h want %h", k, q[k], exp_beat(k)); end
        end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun got %b want 0", overrun_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_overrun();
        test_reset_midstream();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
